// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: architectural widths and hazard-controller state encoding.
package riscv_pipe_pkg;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch mispredict
// redirect/flush, load-use interlock, plus stall/flush performance counters.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             ID_EX_memread,
  input  logic [REG_W-1:0] ID_EX_rd,
  input  logic             EX_branch,
  input  logic             EX_taken,
  input  logic             ID_EX_take,
  input  logic [XLEN-1:0]  EX_target,
  input  logic [XLEN-1:0]  EX_pc_plus4,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             EX_MEM_stall,
  output logic             EX_MEM_flush,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e   state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic        mem_stall, mispredict, load_use, flush_inc;

  assign mem_stall  = mem_req & ~mem_ready;
  assign mispredict = EX_branch & (EX_taken != ID_EX_take);
  assign load_use   = ID_EX_memread & (ID_EX_rd != '0) &
                      ((ID_uses_rs1 & (ID_rs1 == ID_EX_rd)) |
                       (ID_uses_rs2 & (ID_rs2 == ID_EX_rd)));
  assign wait_inc   = wait_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pc_write     = 1'b1;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    EX_MEM_flush = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = '0;
    flush_inc    = 1'b0;
    // Outputs stay at their idle values while reset is held, whatever the inputs.
    if (reset_n) begin
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            pc_write     = 1'b0;
            IF_ID_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            // The detecting cycle is the first wait cycle.
            wait_d       = WAIT_W'(1);
            state_d      = (MEM_TIMEOUT <= 1) ? ERR : MEM_WAIT;
          end else if (mispredict) begin
            pc_redirect  = 1'b1;
            redirect_pc  = EX_taken ? EX_target : EX_pc_plus4;
            IF_ID_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            flush_inc    = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            IF_ID_stall  = 1'b1;
            EX_MEM_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          pc_write     = 1'b0;
          IF_ID_stall  = 1'b1;
          EX_MEM_stall = 1'b1;
          if (mem_ready) begin
            state_d = RUN;
            wait_d  = '0;
          end else if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ERR;
            wait_d  = '0;
          end else begin
            wait_d  = wait_inc;
          end
        end
        ERR: begin
          pc_write     = 1'b0;
          IF_ID_stall  = 1'b1;
          EX_MEM_stall = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // ERR is only left through reset, so the state itself is the sticky flag.
  assign mem_timeout_err = (state_q == ERR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (~pc_write),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );
endmodule
